// File: rtl/pc_ifid_stage.sv
// -----------------------------------------------------------------------------
// pc_ifid_stage
//   PC register plus IF/ID pipeline latch wrapped around the fetch stage.
//   currPC is presented to fetch; the fetched instruction and its PC+2 are
//   captured into the IF/ID register for decode. Handles hazard stalls,
//   branch/jump redirects (flushing the in-flight fetch), HALT detection with a
//   drain phase, and a final HALTED state in which fetch is frozen.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst            in   1   asynchronous reset, active-low
//   currPC         out  16  PC presented to fetch
//   fetch_nextPC   in   16  PC+2 computed by fetch for currPC
//   fetch_instr    in   16  instruction fetched at currPC
//   stall          in   1   hold PC and IF/ID contents
//   redirect       in   1   taken branch/jump: flush IF/ID and reload PC
//   redirect_pc    in   16  redirect target (bit 0 ignored)
//   halt_commit    in   1   HALT reached writeback: enter HALTED
//   ifid_valid     out  1   IF/ID holds a real instruction
//   ifid_instr     out  16  instruction to decode
//   ifid_pc_plus2  out  16  PC+2 of ifid_instr
//   halted         out  1   processor halted
// -----------------------------------------------------------------------------
module pc_ifid_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OP   = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] currPC,
    input  logic [15:0] fetch_nextPC,
    input  logic [15:0] fetch_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt_commit,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pp2_q, pp2_d;
    logic        halted_q, halted_d;

    logic [15:0] target_pc_s;
    logic        is_halt_s;

    // Redirect targets are always halfword aligned.
    assign target_pc_s = {redirect_pc[15:1], 1'b0};
    assign is_halt_s   = (fetch_instr[15:11] == HALT_OP);

    // Next-state and next-output logic; priority halt_commit > redirect > stall > advance.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pp2_d    = pp2_q;
        halted_d = halted_q;

        case (state_q)
            ST_RUN: begin
                if (halt_commit) begin
                    // A same-edge redirect is deliberately dropped here.
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                    valid_d  = 1'b0;
                    instr_d  = NOP_INSTR;
                end else if (redirect) begin
                    // Redirect wins over stall: the in-flight fetch is wrong-path.
                    pc_d    = target_pc_s;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else if (stall) begin
                    pc_d = pc_q;
                end else begin
                    valid_d = 1'b1;
                    instr_d = fetch_instr;
                    pp2_d   = fetch_nextPC;
                    if (is_halt_s) begin
                        // Stop fetching past HALT and wait for it to commit.
                        state_d = ST_DRAIN;
                    end else begin
                        pc_d = fetch_nextPC;
                    end
                end
            end

            ST_DRAIN: begin
                if (halt_commit) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                    valid_d  = 1'b0;
                    instr_d  = NOP_INSTR;
                end else if (redirect) begin
                    // The HALT was on a squashed path; resume fetching.
                    state_d = ST_RUN;
                    pc_d    = target_pc_s;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else if (stall) begin
                    pc_d = pc_q;
                end else begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end

            ST_HALTED: begin
                halted_d = 1'b1;
                valid_d  = 1'b0;
                instr_d  = NOP_INSTR;
            end

            default: begin
                // Illegal encoding: recover into a flushed RUN state.
                state_d  = ST_RUN;
                valid_d  = 1'b0;
                instr_d  = NOP_INSTR;
                halted_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            pp2_q    <= 16'h0000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pp2_q    <= pp2_d;
            halted_q <= halted_d;
        end
    end

    assign currPC        = pc_q;
    assign ifid_valid    = valid_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc_plus2 = pp2_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_pc_ifid_stage.sv
// -----------------------------------------------------------------------------
// tb_pc_ifid_stage
//   Self-checking bench for pc_ifid_stage. Each scenario task pushes the
//   expected {currPC, ifid_valid, ifid_instr, ifid_pc_plus2, halted} onto a
//   scoreboard queue as it drives stimulus, then pops and compares after the
//   clock edge (or immediately, for the asynchronous reset).
// -----------------------------------------------------------------------------
module tb_pc_ifid_stage;

    logic        clk;
    logic        rst;
    logic [15:0] currPC;
    logic [15:0] fetch_nextPC;
    logic [15:0] fetch_instr;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_commit;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        halted;

    int checks;
    int fails;

    logic [49:0] sb[$];
    logic [49:0] got;
    logic [49:0] exp_v;

    pc_ifid_stage dut (
        .clk           (clk),
        .rst           (rst),
        .currPC        (currPC),
        .fetch_nextPC  (fetch_nextPC),
        .fetch_instr   (fetch_instr),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halt_commit   (halt_commit),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [49:0] pack(input logic [15:0] pc, input logic v,
                                         input logic [15:0] ins, input logic [15:0] pp2,
                                         input logic h);
        return {pc, v, ins, pp2, h};
    endfunction

    // Drive one cycle's inputs.
    task automatic drive(input logic [15:0] ins, input logic [15:0] npc, input logic st,
                         input logic rd, input logic [15:0] rpc, input logic hc);
        fetch_instr  = ins;
        fetch_nextPC = npc;
        stall        = st;
        redirect     = rd;
        redirect_pc  = rpc;
        halt_commit  = hc;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        sb.push_back(pack(16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0));
        #12;
        got = {currPC, ifid_valid, ifid_instr, ifid_pc_plus2, halted};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL reset got=%h exp=%h", got, exp_v);
        end
        rst = 1'b1;
    endtask

    // Straight-line fetch of three instructions at PC 0,2,4.
    task automatic test_stream();
        logic [15:0] pc;
        pc = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            drive(16'h4000 + 16'(i), pc + 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b0);
            sb.push_back(pack(pc + 16'h0002, 1'b1, 16'h4000 + 16'(i), pc + 16'h0002, 1'b0));
            tick();
            got = {currPC, ifid_valid, ifid_instr, ifid_pc_plus2, halted};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL stream[%0d] got=%h exp=%h", i, got, exp_v);
            end
            pc = pc + 16'h0002;
        end
    endtask

    // Two stall cycles, then redirect with stall high, then one advance.
    task automatic test_stall_redirect();
        logic [15:0] si [4];
        logic [15:0] sn [4];
        logic        ss [4];
        logic        sr [4];
        logic [15:0] sp [4];
        si = '{16'h4003, 16'h4003, 16'h4003, 16'h4010};
        sn = '{16'h0008, 16'h0008, 16'h0008, 16'h0042};
        ss = '{1'b1, 1'b1, 1'b1, 1'b0};
        sr = '{1'b0, 1'b0, 1'b1, 1'b0};
        sp = '{16'h0000, 16'h0000, 16'h0041, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            drive(si[i], sn[i], ss[i], sr[i], sp[i], 1'b0);
            case (i)
                0, 1:    sb.push_back(pack(16'h0006, 1'b1, 16'h4002, 16'h0006, 1'b0));
                2:       sb.push_back(pack(16'h0040, 1'b0, 16'h0800, 16'h0006, 1'b0));
                default: sb.push_back(pack(16'h0042, 1'b1, 16'h4010, 16'h0042, 1'b0));
            endcase
            tick();
            got = {currPC, ifid_valid, ifid_instr, ifid_pc_plus2, halted};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL stall_redirect[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    // HALT fetched at 0x42, drained with and without stall, then squashed by a redirect.
    task automatic test_squashed_halt();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin
                    drive(16'h0000, 16'h0044, 1'b0, 1'b0, 16'h0000, 1'b0);
                    sb.push_back(pack(16'h0042, 1'b1, 16'h0000, 16'h0044, 1'b0));
                end
                1: begin
                    drive(16'h4444, 16'h0044, 1'b0, 1'b0, 16'h0000, 1'b0);
                    sb.push_back(pack(16'h0042, 1'b0, 16'h0800, 16'h0044, 1'b0));
                end
                2: begin
                    drive(16'h4444, 16'h0044, 1'b1, 1'b0, 16'h0000, 1'b0);
                    sb.push_back(pack(16'h0042, 1'b0, 16'h0800, 16'h0044, 1'b0));
                end
                3: begin
                    drive(16'h4444, 16'h0044, 1'b0, 1'b1, 16'h0100, 1'b0);
                    sb.push_back(pack(16'h0100, 1'b0, 16'h0800, 16'h0044, 1'b0));
                end
                default: begin
                    drive(16'h4020, 16'h0102, 1'b0, 1'b0, 16'h0000, 1'b0);
                    sb.push_back(pack(16'h0102, 1'b1, 16'h4020, 16'h0102, 1'b0));
                end
            endcase
            tick();
            got = {currPC, ifid_valid, ifid_instr, ifid_pc_plus2, halted};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL squashed_halt[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    // HALT at 0x10, drain, commit, then everything ignored; finally async reset while halted.
    task automatic test_halt();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin
                    drive(16'h4444, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0);
                    sb.push_back(pack(16'h0010, 1'b0, 16'h0800, 16'h0102, 1'b0));
                end
                1: begin
                    drive(16'h0000, 16'h0012, 1'b0, 1'b0, 16'h0000, 1'b0);
                    sb.push_back(pack(16'h0010, 1'b1, 16'h0000, 16'h0012, 1'b0));
                end
                2, 3: begin
                    drive(16'h4555, 16'h0012, 1'b0, 1'b0, 16'h0000, 1'b0);
                    sb.push_back(pack(16'h0010, 1'b0, 16'h0800, 16'h0012, 1'b0));
                end
                4: begin
                    drive(16'h4555, 16'h0012, 1'b0, 1'b0, 16'h0000, 1'b1);
                    sb.push_back(pack(16'h0010, 1'b0, 16'h0800, 16'h0012, 1'b1));
                end
                5: begin
                    drive(16'h4000, 16'h0202, 1'b0, 1'b1, 16'h0200, 1'b0);
                    sb.push_back(pack(16'h0010, 1'b0, 16'h0800, 16'h0012, 1'b1));
                end
                default: begin
                    drive(16'h4000, 16'h0202, 1'b1, 1'b0, 16'h0000, 1'b1);
                    sb.push_back(pack(16'h0010, 1'b0, 16'h0800, 16'h0012, 1'b1));
                end
            endcase
            tick();
            got = {currPC, ifid_valid, ifid_instr, ifid_pc_plus2, halted};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL halt[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
        // Reset takes effect without a clock edge.
        drive(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        rst = 1'b0;
        sb.push_back(pack(16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0));
        #1;
        got = {currPC, ifid_valid, ifid_instr, ifid_pc_plus2, halted};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL async_reset got=%h exp=%h", got, exp_v);
        end
        tick();
        rst = 1'b1;
    endtask

    // PC wrap at FFFE, then same-edge halt_commit + redirect.
    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    drive(16'h4444, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0);
                    sb.push_back(pack(16'hFFFE, 1'b0, 16'h0800, 16'h0000, 1'b0));
                end
                1: begin
                    drive(16'h4030, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
                    sb.push_back(pack(16'h0000, 1'b1, 16'h4030, 16'h0000, 1'b0));
                end
                2: begin
                    drive(16'h4031, 16'h0002, 1'b0, 1'b1, 16'h0300, 1'b1);
                    sb.push_back(pack(16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b1));
                end
                default: begin
                    drive(16'h4031, 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b0);
                    sb.push_back(pack(16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b1));
                end
            endcase
            tick();
            got = {currPC, ifid_valid, ifid_instr, ifid_pc_plus2, halted};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL wrap[%0d] got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_stream();
        test_stall_redirect();
        test_squashed_halt();
        test_halt();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
